// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and the memory system.
// Single outstanding valid/ready transaction, word-aligned address.
interface load_store_unit_if;
    logic [31:0] memAddr;
    logic        memValid;
    logic        memWrite;
    logic [3:0]  memWmask;
    logic [31:0] memWdata;
    logic [31:0] memRdata;
    logic        memReady;

    modport master (
        output memAddr, memValid, memWrite, memWmask, memWdata,
        input  memRdata, memReady
    );

    modport slave (
        input  memAddr, memValid, memWrite, memWmask, memWdata,
        output memRdata, memReady
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory stage: one bus transaction per request with lane steering,
// write-mask generation, alignment/funct3 checking and a bus timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic        isLoad,
    input  logic        isStore,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] storeData,
    output logic        busy,
    output logic        done,
    output logic [1:0]  error,
    output logic [31:0] loadData,
    load_store_unit_if.master mem
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ALIGN   = 2'd1;
    localparam logic [1:0] ERR_FUNCT3  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         err_q, err_d;
    logic [31:0]        ld_q, ld_d;
    logic [31:0]        addr_q, addr_d;
    logic [3:0]         wmask_q, wmask_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               write_q, write_d;
    logic               is_load_q, is_load_d;
    logic [2:0]         f3_q, f3_d;
    logic [1:0]         off_q, off_d;
    logic               busy_q, done_q, valid_q;

    logic               accept;
    logic               illegal;
    logic               misaligned;

    // Sign/zero-extend the addressed byte or half out of the read word.
    function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(rd >> {off, 3'b000});
        h = 16'(rd >> {off[1], 4'b0000});
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'h000000, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'h0000, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0]  f3,
                                              input logic [31:0] sd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{sd[7:0]}};
            2'b01:   d = {2{sd[15:0]}};
            default: d = sd;
        endcase
        return d;
    endfunction

    assign accept = start && (isLoad ^ isStore);

    // Loads allow 0,1,2,4,5; stores allow only 0,1,2.
    assign illegal = isLoad ? ((funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7))
                            : (funct3 >= 3'd3);

    assign misaligned = ((funct3[1:0] == 2'b01) && address[0]) ||
                        ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ld_d      = ld_q;
        addr_d    = addr_q;
        wmask_d   = wmask_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        is_load_d = is_load_q;
        f3_d      = f3_q;
        off_d     = off_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    is_load_d = isLoad;
                    f3_d      = funct3;
                    off_d     = address[1:0];
                    if (illegal) begin
                        state_d = DONE;
                        err_d   = ERR_FUNCT3;
                    end else if (misaligned) begin
                        state_d = DONE;
                        err_d   = ERR_ALIGN;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = '0;
                        addr_d  = {address[31:2], 2'b00};
                        write_d = isStore;
                        wmask_d = isStore ? lane_mask(funct3, address[1:0]) : 4'b0000;
                        wdata_d = isStore ? lane_data(funct3, storeData) : 32'h0;
                    end
                end
            end
            ACCESS: begin
                if (mem.memReady) begin
                    state_d = DONE;
                    err_d   = ERR_OK;
                    if (is_load_q) begin
                        ld_d = extend_load(f3_q, off_q, mem.memRdata);
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    state_d = DONE;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_q     <= ERR_OK;
            ld_q      <= 32'h0;
            addr_q    <= 32'h0;
            wmask_q   <= 4'b0000;
            wdata_q   <= 32'h0;
            write_q   <= 1'b0;
            is_load_q <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ld_q      <= ld_d;
            addr_q    <= addr_d;
            wmask_q   <= wmask_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            is_load_q <= is_load_d;
            f3_q      <= f3_d;
            off_q     <= off_d;
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
            valid_q   <= (state_d == ACCESS);
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = err_q;
    assign loadData     = ld_q;
    assign mem.memAddr  = addr_q;
    assign mem.memValid = valid_q;
    assign mem.memWrite = write_q;
    assign mem.memWmask = wmask_q;
    assign mem.memWdata = wdata_q;

endmodule
